// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port arbiter.
// Provides the default geometry of the port, the burst sequencer state
// encoding and the requester identifiers used for round-robin tie breaking.
package dmem_pkg;

  localparam int DEF_AW       = 32;
  localparam int DEF_DW       = 32;
  localparam int DEF_LANES    = 4;
  localparam int DEF_STRIDE_W = 8;

  // Burst sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VBURST = 2'd1,
    VDRAIN = 2'd2
  } state_e;

  // Identity of the last requester to win the port
  typedef enum logic {
    SCAL = 1'b0,
    VEC  = 1'b1
  } req_e;

endpackage

// File: rtl/vlane_addr_gen.sv
// Vector lane address generator.
// Captures the burst base address and word stride on load, then steps one
// lane per advance, accumulating the byte stride modulo 2^AW.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   load         capture base/stride, restart at lane 0
//   base, stride burst base byte address, lane stride in words
//   advance      step to the next lane (wraps to lane 0 after the last)
//   addr         byte address of the current lane
//   lane         current lane index
//   last         current lane is LANES-1
module vlane_addr_gen
  import dmem_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int STRIDE_W = DEF_STRIDE_W,
  parameter int LANES    = DEF_LANES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [AW-1:0]              base,
  input  logic [STRIDE_W-1:0]        stride,
  input  logic                       advance,
  output logic [AW-1:0]              addr,
  output logic [$clog2(LANES)-1:0]   lane,
  output logic                       last
);

  localparam int LW = $clog2(LANES);

  logic [AW-1:0] addr_r;
  logic [AW-1:0] step_r;
  logic [LW-1:0] lane_r;
  logic          last_s;

  // Stride is in words; the address is a byte address
  logic [AW-1:0] stride_bytes_s;
  assign stride_bytes_s = {{(AW-STRIDE_W-2){1'b0}}, stride, 2'b00};

  assign last_s = (lane_r == LW'(LANES-1));

  // Lane counter and address accumulator
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_r <= {AW{1'b0}};
      step_r <= {AW{1'b0}};
      lane_r <= {LW{1'b0}};
    end else if (load) begin
      addr_r <= base;
      step_r <= stride_bytes_s;
      lane_r <= {LW{1'b0}};
    end else if (advance) begin
      addr_r <= addr_r + step_r;
      lane_r <= last_s ? {LW{1'b0}} : lane_r + LW'(1);
    end
  end

  assign addr = addr_r;
  assign lane = lane_r;
  assign last = last_s;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter.
// Shares one synchronous-read data memory port between the scalar pipeline
// (zero-latency pass-through when granted) and the vector load/store unit
// (non-preemptible strided bursts of LANES words).
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   s_req/s_we/s_addr/s_wdata         scalar request, held until s_gnt
//   s_gnt                             scalar access issued this cycle
//   s_rvalid/s_rdata                  scalar read return, cycle after grant
//   v_req/v_we/v_base/v_stride/v_wdata vector burst request, held until accept
//   v_busy                            burst in progress
//   v_done                            one-cycle completion pulse
//   v_rdata                           load result, lane k at [k*DW +: DW]
//   mem_addr/mem_we/mem_wdata         memory request
//   mem_rdata                         memory read data, cycle after address
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int LANES    = DEF_LANES,
  parameter int STRIDE_W = DEF_STRIDE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_req,
  input  logic                  s_we,
  input  logic [AW-1:0]         s_addr,
  input  logic [DW-1:0]         s_wdata,
  output logic                  s_gnt,
  output logic                  s_rvalid,
  output logic [DW-1:0]         s_rdata,
  input  logic                  v_req,
  input  logic                  v_we,
  input  logic [AW-1:0]         v_base,
  input  logic [STRIDE_W-1:0]   v_stride,
  input  logic [LANES*DW-1:0]   v_wdata,
  output logic                  v_busy,
  output logic                  v_done,
  output logic [LANES*DW-1:0]   v_rdata,
  output logic [AW-1:0]         mem_addr,
  output logic                  mem_we,
  output logic [DW-1:0]         mem_wdata,
  input  logic [DW-1:0]         mem_rdata
);

  localparam int LW = $clog2(LANES);

  state_e              state_r;
  state_e              state_nxt_s;
  req_e                rr_last_r;
  logic                s_win_s;
  logic                s_gnt_s;
  logic                v_acc_s;
  logic                v_we_r;
  logic [LANES*DW-1:0] v_wdata_r;
  logic [LANES*DW-1:0] v_rdata_r;
  logic                rd_pend_r;
  logic [LW-1:0]       rd_lane_r;
  logic                s_rvalid_r;
  logic [DW-1:0]       s_rdata_hold_r;
  logic [AW-1:0]       mem_addr_s;
  logic                mem_we_s;
  logic [DW-1:0]       mem_wdata_s;
  logic [AW-1:0]       mem_addr_hold_r;
  logic [DW-1:0]       mem_wdata_hold_r;
  logic [AW-1:0]       gen_addr_s;
  logic [LW-1:0]       gen_lane_s;
  logic                gen_last_s;
  logic                in_burst_s;

  assign in_burst_s = (state_r == VBURST);

  vlane_addr_gen #(
    .AW       (AW),
    .STRIDE_W (STRIDE_W),
    .LANES    (LANES)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (v_acc_s),
    .base    (v_base),
    .stride  (v_stride),
    .advance (in_burst_s),
    .addr    (gen_addr_s),
    .lane    (gen_lane_s),
    .last    (gen_last_s)
  );

  // Arbitration in IDLE: scalar wins unless the vector is also asking and
  // the scalar side won last time. Grants are masked while reset is asserted
  // so the memory never sees a write during reset.
  always_comb begin
    s_win_s = 1'b0;
    v_acc_s = 1'b0;
    if (state_r == IDLE) begin
      s_win_s = s_req & (~v_req | (rr_last_r == VEC));
      v_acc_s = v_req & ~s_win_s & rst;
    end else begin
      s_win_s = 1'b0;
      v_acc_s = 1'b0;
    end
    s_gnt_s = s_win_s & rst;
  end

  // Next-state logic of the burst sequencer
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = v_acc_s ? VBURST : IDLE;
      VBURST:  state_nxt_s = gen_last_s ? VDRAIN : VBURST;
      VDRAIN:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Memory request mux; with no access the address and data just hold
  always_comb begin
    mem_addr_s  = mem_addr_hold_r;
    mem_we_s    = 1'b0;
    mem_wdata_s = mem_wdata_hold_r;
    if (s_gnt_s) begin
      mem_addr_s  = s_addr;
      mem_we_s    = s_we;
      mem_wdata_s = s_wdata;
    end else if (in_burst_s) begin
      mem_addr_s  = gen_addr_s;
      mem_we_s    = v_we_r;
      mem_wdata_s = v_wdata_r[gen_lane_s*DW +: DW];
    end else begin
      mem_addr_s  = mem_addr_hold_r;
      mem_we_s    = 1'b0;
      mem_wdata_s = mem_wdata_hold_r;
    end
  end

  // Sequencer state and round-robin history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      rr_last_r <= VEC;
    end else begin
      state_r <= state_nxt_s;
      if (s_gnt_s) begin
        rr_last_r <= SCAL;
      end else if (v_acc_s) begin
        rr_last_r <= VEC;
      end
    end
  end

  // Vector request capture at accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_we_r    <= 1'b0;
      v_wdata_r <= {(LANES*DW){1'b0}};
    end else if (v_acc_s) begin
      v_we_r    <= v_we;
      v_wdata_r <= v_wdata;
    end
  end

  // Read return: a load beat's data arrives one cycle later, so the lane
  // index travels with a pending flag; scalar reads raise s_rvalid likewise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend_r      <= 1'b0;
      rd_lane_r      <= {LW{1'b0}};
      v_rdata_r      <= {(LANES*DW){1'b0}};
      s_rvalid_r     <= 1'b0;
      s_rdata_hold_r <= {DW{1'b0}};
    end else begin
      rd_pend_r  <= in_burst_s & ~v_we_r;
      rd_lane_r  <= gen_lane_s;
      s_rvalid_r <= s_gnt_s & ~s_we;
      if (rd_pend_r) begin
        v_rdata_r[rd_lane_r*DW +: DW] <= mem_rdata;
      end
      if (s_rvalid_r) begin
        s_rdata_hold_r <= mem_rdata;
      end
    end
  end

  // Remember the last address/data presented so idle cycles hold them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr_hold_r  <= {AW{1'b0}};
      mem_wdata_hold_r <= {DW{1'b0}};
    end else begin
      mem_addr_hold_r  <= mem_addr_s;
      mem_wdata_hold_r <= mem_wdata_s;
    end
  end

  assign s_gnt     = s_gnt_s;
  assign s_rvalid  = s_rvalid_r;
  // Read data comes straight from memory in the valid cycle, then holds
  assign s_rdata   = s_rvalid_r ? mem_rdata : s_rdata_hold_r;
  assign v_busy    = (state_r != IDLE);
  assign v_done    = (state_r == VDRAIN);
  assign v_rdata   = v_rdata_r;
  assign mem_addr  = mem_addr_s;
  assign mem_we    = mem_we_s;
  assign mem_wdata = mem_wdata_s;

endmodule
